// File: rtl/id_regfile_scoreboard_if.sv
// ID-stage register-file / load-use scoreboard bus.
// Revision 1.0 - initial release
`default_nettype none

interface id_regfile_scoreboard_if;
  logic [2:0]  read1RegSel;
  logic [2:0]  read2RegSel;
  logic        read1Used;
  logic        read2Used;
  logic [15:0] read1Data;
  logic [15:0] read2Data;
  logic        writeEn;
  logic [2:0]  writeRegSel;
  logic [15:0] writeData;
  logic        issue_MemRead;
  logic        issue_RegWrite;
  logic [2:0]  issue_writeRegSel;
  logic        flush;
  logic        Stall_DM;
  logic        stall;
  logic [7:0]  pending;

  modport master (
    output read1RegSel, read2RegSel, read1Used, read2Used,
    output writeEn, writeRegSel, writeData,
    output issue_MemRead, issue_RegWrite, issue_writeRegSel,
    output flush, Stall_DM,
    input  read1Data, read2Data, stall, pending
  );

  modport slave (
    input  read1RegSel, read2RegSel, read1Used, read2Used,
    input  writeEn, writeRegSel, writeData,
    input  issue_MemRead, issue_RegWrite, issue_writeRegSel,
    input  flush, Stall_DM,
    output read1Data, read2Data, stall, pending
  );
endinterface

`default_nettype wire

// File: rtl/id_regfile_scoreboard.sv
// Decode-stage 8x16 register file with writeback bypass and time-based load-use scoreboard.
// Revision 1.0 - initial release
`default_nettype none

module id_regfile_scoreboard #(
  parameter int LOAD_USE_CYCLES = 1
) (
  input wire logic               clk,
  input wire logic               rst,
  id_regfile_scoreboard_if.slave bus
);

  localparam logic [1:0] RELOAD = 2'(LOAD_USE_CYCLES);

  logic [15:0] rf  [8];
  logic [1:0]  cnt [8];
  logic [7:0]  pending;
  logic        stall;
  logic        issue;
  logic        load_issue;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 8; r++) rf[r] <= '0;
    end else if (bus.writeEn) begin
      rf[bus.writeRegSel] <= bus.writeData;
    end
  end

  // Counters are purely time-based: writebacks never touch them, and a
  // data-memory stall freezes them along with the rest of the pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 8; r++) cnt[r] <= '0;
    end else if (!bus.Stall_DM) begin
      for (int r = 0; r < 8; r++) begin
        if (load_issue && (bus.issue_writeRegSel == 3'(r))) begin
          cnt[r] <= RELOAD;
        end else if (cnt[r] != 2'd0) begin
          cnt[r] <= cnt[r] - 2'd1;
        end
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int r = 0; r < 8; r++) pending[r] = (cnt[r] != 2'd0);
  end

  assign stall      = (bus.read1Used && pending[bus.read1RegSel]) ||
                      (bus.read2Used && pending[bus.read2RegSel]);
  assign issue      = !stall && !bus.flush && !bus.Stall_DM;
  assign load_issue = issue && bus.issue_MemRead && bus.issue_RegWrite;

  assign bus.read1Data = (bus.writeEn && (bus.writeRegSel == bus.read1RegSel)) ?
                         bus.writeData : rf[bus.read1RegSel];
  assign bus.read2Data = (bus.writeEn && (bus.writeRegSel == bus.read2RegSel)) ?
                         bus.writeData : rf[bus.read2RegSel];
  assign bus.stall     = stall;
  assign bus.pending   = pending;

endmodule

`default_nettype wire

// File: tb/tb_id_regfile_scoreboard.sv
// Scoreboard bench for id_regfile_scoreboard; runs LOAD_USE_CYCLES=1 and =3 side by side.
// Revision 1.0 - initial release
`default_nettype none

module tb_id_regfile_scoreboard;

  typedef struct packed {
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic        u1;
    logic        u2;
    logic        we;
    logic [2:0]  ws;
    logic [15:0] wd;
    logic        mr;
    logic        rw;
    logic [2:0]  iw;
    logic        fl;
    logic        sdm;
  } stim_t;

  typedef struct packed {
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic        stall;
    logic [7:0]  pend;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_regfile_scoreboard_if bus1 ();
  id_regfile_scoreboard_if bus3 ();

  id_regfile_scoreboard #(.LOAD_USE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  id_regfile_scoreboard #(.LOAD_USE_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int checks   = 0;
  int failures = 0;

  obs_t        exp_q[$];
  obs_t        obs[2];
  logic [15:0] m_rf[8];
  int          m_cnt[2][8];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, expv);
    end
  endtask

  function automatic int lu(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t load(input logic [2:0] r);
    stim_t s;
    s = '0;
    s.mr = 1'b1;
    s.rw = 1'b1;
    s.iw = r;
    return s;
  endfunction

  function automatic stim_t reader(input logic [2:0] r);
    stim_t s;
    s = '0;
    s.r1 = r;
    s.u1 = 1'b1;
    return s;
  endfunction

  function automatic obs_t predict(input int k, input stim_t s);
    obs_t o;
    o.rd1   = (s.we && s.ws == s.r1) ? s.wd : m_rf[s.r1];
    o.rd2   = (s.we && s.ws == s.r2) ? s.wd : m_rf[s.r2];
    o.stall = (s.u1 && m_cnt[k][s.r1] != 0) || (s.u2 && m_cnt[k][s.r2] != 0);
    for (int r = 0; r < 8; r++) o.pend[r] = (m_cnt[k][r] != 0);
    return o;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 8; r++) begin
      m_rf[r]     = '0;
      m_cnt[0][r] = 0;
      m_cnt[1][r] = 0;
    end
  endtask

  task automatic model_edge(input stim_t s);
    obs_t p;
    logic iss;
    if (!rst) begin
      model_clear();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      p   = predict(k, s);
      iss = !p.stall && !s.fl && !s.sdm;
      if (!s.sdm) begin
        for (int r = 0; r < 8; r++) begin
          if (iss && s.mr && s.rw && s.iw == 3'(r)) m_cnt[k][r] = lu(k);
          else if (m_cnt[k][r] > 0)                 m_cnt[k][r] = m_cnt[k][r] - 1;
        end
      end
    end
    if (s.we) m_rf[s.ws] = s.wd;
  endtask

  task automatic drive(input stim_t s);
    bus1.read1RegSel = s.r1;  bus3.read1RegSel = s.r1;
    bus1.read2RegSel = s.r2;  bus3.read2RegSel = s.r2;
    bus1.read1Used   = s.u1;  bus3.read1Used   = s.u1;
    bus1.read2Used   = s.u2;  bus3.read2Used   = s.u2;
    bus1.writeEn     = s.we;  bus3.writeEn     = s.we;
    bus1.writeRegSel = s.ws;  bus3.writeRegSel = s.ws;
    bus1.writeData   = s.wd;  bus3.writeData   = s.wd;
    bus1.issue_MemRead     = s.mr;  bus3.issue_MemRead     = s.mr;
    bus1.issue_RegWrite    = s.rw;  bus3.issue_RegWrite    = s.rw;
    bus1.issue_writeRegSel = s.iw;  bus3.issue_writeRegSel = s.iw;
    bus1.flush       = s.fl;  bus3.flush       = s.fl;
    bus1.Stall_DM    = s.sdm; bus3.Stall_DM    = s.sdm;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic run_cycle(input stim_t s);
    obs_t e;
    drive(s);
    for (int k = 0; k < 2; k++) exp_q.push_back(predict(k, s));
    @(negedge clk);
    obs[0] = '{bus1.read1Data, bus1.read2Data, bus1.stall, bus1.pending};
    obs[1] = '{bus3.read1Data, bus3.read2Data, bus3.stall, bus3.pending};
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      check_value($sformatf("L%0d rd1", lu(k)),   32'(obs[k].rd1),   32'(e.rd1));
      check_value($sformatf("L%0d rd2", lu(k)),   32'(obs[k].rd2),   32'(e.rd2));
      check_value($sformatf("L%0d stall", lu(k)), 32'(obs[k].stall), 32'(e.stall));
      check_value($sformatf("L%0d pend", lu(k)),  32'(obs[k].pend),  32'(e.pend));
    end
    model_edge(s);
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    for (int i = 0; i < 4; i++) run_cycle(idle());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    int st1, st3, p04, pb1_1, pb1_3;

    model_clear();
    drive(idle());
    @(posedge clk);
    #1;

    // Reset held for three cycles, then read every register
    for (int i = 0; i < 3; i++) run_cycle(idle());
    check_value("reset stall", 32'(obs[0].stall), 32'd0);
    check_value("reset pend",  32'(obs[1].pend),  32'd0);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s = idle();
      s.r1 = 3'(i); s.r2 = 3'(7 - i); s.u1 = 1'b1; s.u2 = 1'b1;
      run_cycle(s);
      check_value("reset rd1", 32'(obs[0].rd1), 32'd0);
    end

    // Dual-port bypass of a writeback
    s = idle();
    s.we = 1'b1; s.ws = 3'd3; s.wd = 16'hBEEF; s.r1 = 3'd3; s.r2 = 3'd3;
    run_cycle(s);
    check_value("bypass rd1", 32'(obs[0].rd1), 32'hBEEF);
    check_value("bypass rd2", 32'(obs[1].rd2), 32'hBEEF);
    run_cycle(reader(3'd3));
    check_value("rf3 after write", 32'(obs[0].rd1), 32'hBEEF);

    // Load-use on R2
    gap();
    run_cycle(load(3'd2));
    st1 = 0; st3 = 0; p04 = 0;
    for (int i = 0; i < 4; i++) begin
      run_cycle(reader(3'd2));
      st1 += int'(obs[0].stall);
      st3 += int'(obs[1].stall);
      p04 += int'(obs[0].pend == 8'h04);
    end
    check_value("loaduse L1 stalls", 32'(st1), 32'd1);
    check_value("loaduse L3 stalls", 32'(st3), 32'd3);
    check_value("loaduse L1 pend04", 32'(p04), 32'd1);

    // Stall_DM for two cycles during the stall stretches it
    gap();
    run_cycle(load(3'd2));
    st1 = 0; st3 = 0;
    for (int i = 0; i < 7; i++) begin
      s = reader(3'd2);
      s.sdm = (i < 2);
      run_cycle(s);
      st1 += int'(obs[0].stall);
      st3 += int'(obs[1].stall);
    end
    check_value("freeze L1 stalls", 32'(st1), 32'd3);
    check_value("freeze L3 stalls", 32'(st3), 32'd5);

    // Flushed load never arms the counter
    gap();
    s = load(3'd5);
    s.fl = 1'b1;
    run_cycle(s);
    st1 = 0; st3 = 0;
    for (int i = 0; i < 3; i++) begin
      run_cycle(reader(3'd5));
      st1 += int'(obs[0].stall);
      st3 += int'(obs[1].stall);
    end
    check_value("flushed load L1 stalls", 32'(st1), 32'd0);
    check_value("flushed load L3 stalls", 32'(st3), 32'd0);

    // Flush does not stop an armed counter from draining
    gap();
    run_cycle(load(3'd5));
    s = reader(3'd5);
    s.fl = 1'b1;
    run_cycle(s);
    check_value("flush stall L1", 32'(obs[0].stall), 32'd1);
    run_cycle(idle());
    check_value("flush drain L1", 32'(obs[0].pend), 32'h00);
    check_value("flush drain L3", 32'(obs[1].pend), 32'h20);

    // Back-to-back loads to R1 reload the counter
    gap();
    run_cycle(load(3'd1));
    pb1_1 = 0; pb1_3 = 0;
    run_cycle(load(3'd1));
    pb1_1 += int'(obs[0].pend[1]);
    pb1_3 += int'(obs[1].pend[1]);
    for (int i = 0; i < 5; i++) begin
      run_cycle(idle());
      pb1_1 += int'(obs[0].pend[1]);
      pb1_3 += int'(obs[1].pend[1]);
    end
    check_value("reload L1 pending cycles", 32'(pb1_1), 32'd2);
    check_value("reload L3 pending cycles", 32'(pb1_3), 32'd4);

    // Asynchronous reset in the middle of a stall
    run_cycle(load(3'd1));
    drive(reader(3'd1));
    #2;
    check_value("pre-reset stall L1", 32'(bus1.stall), 32'd1);
    check_value("pre-reset stall L3", 32'(bus3.stall), 32'd1);
    rst = 1'b0;
    #1;
    check_value("async reset stall L1", 32'(bus1.stall),   32'd0);
    check_value("async reset stall L3", 32'(bus3.stall),   32'd0);
    check_value("async reset pend L1",  32'(bus1.pending), 32'd0);
    check_value("async reset pend L3",  32'(bus3.pending), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
    s = reader(3'd3);
    s.r2 = 3'd1; s.u2 = 1'b1;
    run_cycle(s);
    check_value("rf3 cleared by reset", 32'(obs[0].rd1), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 120; i++) begin
      s.r1  = 3'($urandom_range(0, 7));
      s.r2  = 3'($urandom_range(0, 7));
      s.u1  = 1'($urandom_range(0, 1));
      s.u2  = 1'($urandom_range(0, 1));
      s.we  = 1'($urandom_range(0, 1));
      s.ws  = 3'($urandom_range(0, 7));
      s.wd  = 16'($urandom);
      s.mr  = ($urandom_range(0, 2) == 0);
      s.rw  = ($urandom_range(0, 3) != 0);
      s.iw  = 3'($urandom_range(0, 7));
      s.fl  = ($urandom_range(0, 7) == 0);
      s.sdm = ($urandom_range(0, 5) == 0);
      run_cycle(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
